// File: rtl/toggle_cover_detector.sv
// Toggle-coverage front end: per-bit one-cycle valid pulses when a bit has seen both edges.
// Optional macro TOGGLE_COVER_REPEAT_EN: pulse valid on every observed transition instead of once.
module toggle_cover_detector #(
  parameter int unsigned WIDTH = 39,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sig,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] valid,
  output logic [CW-1:0]    covered_count,
  output logic             all_covered
);

  typedef enum logic {UNPRIMED, ACTIVE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] prev, prev_next;
  logic [WIDTH-1:0] seen_rise, seen_rise_next;
  logic [WIDTH-1:0] seen_fall, seen_fall_next;
  logic [WIDTH-1:0] covered, covered_next;
  logic [WIDTH-1:0] valid_next;
  logic [WIDTH-1:0] rise, fall;
  logic [CW-1:0]    count_next;
  logic             all_next;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= UNPRIMED;
      prev          <= '0;
      seen_rise     <= '0;
      seen_fall     <= '0;
      covered       <= '0;
      valid         <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      state         <= state_next;
      prev          <= prev_next;
      seen_rise     <= seen_rise_next;
      seen_fall     <= seen_fall_next;
      covered       <= covered_next;
      valid         <= valid_next;
      covered_count <= count_next;
      all_covered   <= all_next;
    end
  end

  // Next-state: the first enabled edge after UNPRIMED only loads prev, so stale values never compare
  always_comb begin
    state_next     = state;
    prev_next      = prev;
    seen_rise_next = seen_rise;
    seen_fall_next = seen_fall;
    covered_next   = covered;
    valid_next     = '0;
    rise           = '0;
    fall           = '0;

    if (clear) begin
      state_next     = UNPRIMED;
      prev_next      = sig;
      seen_rise_next = '0;
      seen_fall_next = '0;
      covered_next   = '0;
    end else if (!enable) begin
      state_next = UNPRIMED;
    end else if (state == UNPRIMED) begin
      state_next = ACTIVE;
      prev_next  = sig;
    end else begin
      rise           = ~prev & sig;
      fall           = prev & ~sig;
      prev_next      = sig;
      seen_rise_next = seen_rise | rise;
      seen_fall_next = seen_fall | fall;
      covered_next   = seen_rise_next & seen_fall_next;
`ifdef TOGGLE_COVER_REPEAT_EN
      valid_next     = rise | fall;
`else
      valid_next     = covered_next & ~covered;
`endif
    end

    count_next = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      count_next = count_next + CW'(covered_next[i]);
    end
    all_next = (count_next == CW'(WIDTH));
  end

endmodule

// File: tb/tb_toggle_cover_detector.sv
// Directed self-checking bench for toggle_cover_detector (WIDTH=39).
// Honours TOGGLE_COVER_REPEAT_EN when the design is built with it.
module tb_toggle_cover_detector;

  localparam int unsigned W  = 39;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clock;
  logic          reset;
  logic [W-1:0]  sig;
  logic          enable;
  logic          clear;
  logic [W-1:0]  valid;
  logic [CW-1:0] covered_count;
  logic          all_covered;

  int checks;
  int errors;

  logic [W-1:0] all_ones;
  logic [W-1:0] b3;
  logic [W-1:0] b5;
  logic [W-1:0] exp_v;

  toggle_cover_detector #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .sig(sig),
    .enable(enable),
    .clear(clear),
    .valid(valid),
    .covered_count(covered_count),
    .all_covered(all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one posedge; outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; clear = 1'b0; sig = all_ones;
    tick();
    sig = '0;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL reset_valid: got %h expected %h", valid, W'(0)); end
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL reset_count: got %0d expected 0", covered_count); end
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL reset_all: got %b expected 0", all_covered); end
  endtask

  task automatic test_priming();
    reset = 1'b1; enable = 1'b1; sig = all_ones;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL prime_valid: got %h expected 0", valid); end
    sig = '0;
    tick();
    exp_v = '0;
`ifdef TOGGLE_COVER_REPEAT_EN
    exp_v = all_ones;
`endif
    checks++; if (valid !== exp_v) begin errors++; $display("FAIL fall_valid: got %h expected %h", valid, exp_v); end
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL fall_count: got %0d expected 0", covered_count); end
  endtask

  task automatic test_coverage();
    sig = W'(1);
    tick();
    checks++; if (valid !== W'(1)) begin errors++; $display("FAIL bit0_valid: got %h expected %h", valid, W'(1)); end
    checks++; if (covered_count !== CW'(1)) begin errors++; $display("FAIL bit0_count: got %0d expected 1", covered_count); end
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL bit0_all: got %b expected 0", all_covered); end
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL bit0_one_cycle: got %h expected 0", valid); end
    sig = '0;
    tick();
    exp_v = '0;
`ifdef TOGGLE_COVER_REPEAT_EN
    exp_v = W'(1);
`endif
    checks++; if (valid !== exp_v) begin errors++; $display("FAIL bit0_retoggle: got %h expected %h", valid, exp_v); end
    sig = all_ones;
    tick();
    exp_v = all_ones & ~W'(1);
`ifdef TOGGLE_COVER_REPEAT_EN
    exp_v = all_ones;
`endif
    checks++; if (valid !== exp_v) begin errors++; $display("FAIL all_rise_valid: got %h expected %h", valid, exp_v); end
    checks++; if (covered_count !== CW'(39)) begin errors++; $display("FAIL all_rise_count: got %0d expected 39", covered_count); end
    checks++; if (all_covered !== 1'b1) begin errors++; $display("FAIL all_rise_all: got %b expected 1", all_covered); end
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL all_rise_one_cycle: got %h expected 0", valid); end
    checks++; if (covered_count !== CW'(39)) begin errors++; $display("FAIL count_sticky: got %0d expected 39", covered_count); end
  endtask

  task automatic test_clear();
    clear = 1'b1; sig = all_ones & ~b3;
    tick();
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL clear_count: got %0d expected 0", covered_count); end
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL clear_all: got %b expected 0", all_covered); end
    checks++; if (valid !== '0) begin errors++; $display("FAIL clear_valid: got %h expected 0", valid); end
    clear = 1'b0; sig = all_ones;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL clear_prime_valid: got %h expected 0", valid); end
    sig = all_ones & ~b3;
    tick();
    exp_v = '0;
`ifdef TOGGLE_COVER_REPEAT_EN
    exp_v = b3;
`endif
    checks++; if (valid !== exp_v) begin errors++; $display("FAIL b3_fall_valid: got %h expected %h", valid, exp_v); end
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL b3_fall_count: got %0d expected 0", covered_count); end
    sig = all_ones;
    tick();
    checks++; if (valid !== b3) begin errors++; $display("FAIL b3_rise_valid: got %h expected %h", valid, b3); end
    checks++; if (covered_count !== CW'(1)) begin errors++; $display("FAIL b3_rise_count: got %0d expected 1", covered_count); end
  endtask

  task automatic test_enable_gap();
    clear = 1'b1; sig = all_ones & ~b5;
    tick();
    clear = 1'b0;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL gap_prime_valid: got %h expected 0", valid); end
    sig = all_ones;
    tick();
    exp_v = '0;
`ifdef TOGGLE_COVER_REPEAT_EN
    exp_v = b5;
`endif
    checks++; if (valid !== exp_v) begin errors++; $display("FAIL b5_rise_valid: got %h expected %h", valid, exp_v); end
    enable = 1'b0; sig = all_ones & ~b5;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL dis_fall_valid: got %h expected 0", valid); end
    sig = all_ones;
    tick();
    sig = all_ones & ~b5;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL dis_toggle_valid: got %h expected 0", valid); end
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL dis_count: got %0d expected 0", covered_count); end
    enable = 1'b1;
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL reprime_valid: got %h expected 0", valid); end
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL reprime_count: got %0d expected 0", covered_count); end
    sig = all_ones;
    tick();
    exp_v = '0;
`ifdef TOGGLE_COVER_REPEAT_EN
    exp_v = b5;
`endif
    checks++; if (valid !== exp_v) begin errors++; $display("FAIL b5_rerise_valid: got %h expected %h", valid, exp_v); end
    sig = all_ones & ~b5;
    tick();
    checks++; if (valid !== b5) begin errors++; $display("FAIL b5_fall_valid: got %h expected %h", valid, b5); end
    checks++; if (covered_count !== CW'(1)) begin errors++; $display("FAIL b5_count: got %0d expected 1", covered_count); end
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL b5_one_cycle: got %h expected 0", valid); end
  endtask

`ifdef TOGGLE_COVER_REPEAT_EN
  task automatic test_repeat();
    clear = 1'b1; sig = '0;
    tick();
    clear = 1'b0; sig = W'(1);
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL rep_prime: got %h expected 0", valid); end
    for (int k = 0; k < 3; k++) begin
      sig = (k % 2 == 0) ? W'(0) : W'(1);
      tick();
      checks++; if (valid !== W'(1)) begin errors++; $display("FAIL rep_pulse%0d: got %h expected %h", k, valid, W'(1)); end
    end
    checks++; if (covered_count !== CW'(1)) begin errors++; $display("FAIL rep_count: got %0d expected 1", covered_count); end
    tick();
    checks++; if (valid !== '0) begin errors++; $display("FAIL rep_idle: got %h expected 0", valid); end
  endtask
`endif

  task automatic test_reset_over_clear();
    reset = 1'b0; clear = 1'b1;
    tick();
    checks++; if (covered_count !== CW'(0)) begin errors++; $display("FAIL rst_clr_count: got %0d expected 0", covered_count); end
    checks++; if (valid !== '0) begin errors++; $display("FAIL rst_clr_valid: got %h expected 0", valid); end
    reset = 1'b1; clear = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    all_ones = '1;
    b3 = W'(1) << 3;
    b5 = W'(1) << 5;
    reset = 1'b0; enable = 1'b0; clear = 1'b0; sig = '0;
    #2;
    test_reset();
    test_priming();
    test_coverage();
    test_clear();
    test_enable_gap();
`ifdef TOGGLE_COVER_REPEAT_EN
    test_repeat();
`endif
    test_reset_over_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
